// File: rtl/circ_alloc_pkg.sv
// Shared helpers for the circular slot allocator: pointer wrap and occupancy popcount.
package circ_alloc_pkg;

    localparam int POPCNT_MAX_W = 1024;

    // Explicit compare-and-wrap keeps the pointer legal for non-power-of-two slot counts.
    function automatic int wrap_inc(input int idx, input int w);
        return (idx == w - 1) ? 0 : idx + 1;
    endfunction

    function automatic int popcount(input logic [POPCNT_MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/circ_ffz.sv
// Combinational circular find-first-zero: lowest zero at or above pos_i, else lowest zero overall.
module circ_ffz #(
    parameter int W  = 32,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  x_i,
    input  logic [IW-1:0] pos_i,
    output logic [W-1:0]  y_o,
    output logic [IW-1:0] y_enc_o,
    output logic          any_o
);

    logic [W-1:0] w_zero;
    logic [W-1:0] w_ge_mask;
    logic [W-1:0] w_hi;
    logic [W-1:0] w_sel;

    // Split search instead of a barrel rotate, so unused index codes past W-1 never enter the
    // candidate set and the wrap W-1 -> 0 falls out of the low-half fallback.
    always_comb begin
        w_zero    = ~x_i;
        w_ge_mask = '0;
        for (int i = 0; i < W; i++) begin
            w_ge_mask[i] = (IW'(i) >= pos_i);
        end
        w_hi  = w_zero & w_ge_mask;
        w_sel = (|w_hi) ? w_hi : w_zero;
        y_o   = w_sel & (~w_sel + W'(1));
        any_o = |w_zero;
    end

    always_comb begin
        y_enc_o = '0;
        for (int i = 0; i < W; i++) begin
            if (y_o[i]) begin
                y_enc_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/circ_slot_alloc.sv
// W-entry slot allocator: grants one free slot per cycle, releases on the free port, sticky error.
module circ_slot_alloc
    import circ_alloc_pkg::*;
#(
    parameter int   W           = 32,
    parameter logic ROUND_ROBIN = 1'b1,
    parameter int   IW          = $clog2(W)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          flush_i,
    input  logic          alloc_vld_i,
    output logic          alloc_rdy_o,
    output logic [IW-1:0] alloc_id_o,
    output logic [W-1:0]  alloc_oh_o,
    input  logic          free_vld_i,
    input  logic [IW-1:0] free_id_i,
    output logic [IW:0]   free_cnt_o,
    output logic [W-1:0]  occ_o,
    output logic          err_o
);

    localparam logic [IW:0] LP_W = (IW+1)'(W);

    logic [W-1:0]  r_occ;
    logic [IW-1:0] r_ptr;
    logic [IW:0]   r_free_cnt;
    logic          r_err;

    logic [IW-1:0] w_pos;
    logic [W-1:0]  w_grant_oh;
    logic [IW-1:0] w_grant_id;
    logic          w_any_free;
    logic          w_fire;
    logic          w_free_in_range;
    logic [W-1:0]  w_free_mask;
    logic          w_free_legal;
    logic          w_free_err;
    logic [W-1:0]  w_occ_nxt;

    assign w_pos = ROUND_ROBIN ? r_ptr : '0;

    circ_ffz #(
        .W  (W),
        .IW (IW)
    ) u_ffz (
        .x_i     (r_occ),
        .pos_i   (w_pos),
        .y_o     (w_grant_oh),
        .y_enc_o (w_grant_id),
        .any_o   (w_any_free)
    );

    assign w_fire          = alloc_vld_i & w_any_free;
    assign w_free_in_range = ({1'b0, free_id_i} < LP_W);
    assign w_free_mask     = (free_vld_i && w_free_in_range) ? (W'(1) << free_id_i) : '0;
    assign w_free_legal    = |(w_free_mask & r_occ);
    assign w_free_err      = free_vld_i & ~w_free_legal;
    // Grant sees pre-update occupancy, so a grant and a legal free never hit the same bit;
    // an illegal free of the granted slot clears nothing and the grant leaves it occupied.
    assign w_occ_nxt       = (r_occ & ~w_free_mask) | (w_fire ? w_grant_oh : '0);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_occ      <= '0;
            r_ptr      <= '0;
            r_free_cnt <= LP_W;
            r_err      <= 1'b0;
        end else if (flush_i) begin
            r_occ      <= '0;
            r_ptr      <= '0;
            r_free_cnt <= LP_W;
        end else begin
            r_occ <= w_occ_nxt;
            if (ROUND_ROBIN && w_fire) begin
                r_ptr <= IW'(wrap_inc(int'(w_grant_id), W));
            end
            case ({w_free_legal, w_fire})
                2'b10:   r_free_cnt <= r_free_cnt + 1'b1;
                2'b01:   r_free_cnt <= r_free_cnt - 1'b1;
                default: r_free_cnt <= r_free_cnt;
            endcase
            if (w_free_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign alloc_rdy_o = w_any_free;
    assign alloc_id_o  = w_grant_id;
    assign alloc_oh_o  = w_grant_oh;
    assign free_cnt_o  = r_free_cnt;
    assign occ_o       = r_occ;
    assign err_o       = r_err;

    a_free_cnt_matches_occ: assert property (@(posedge clk) disable iff (arst)
        int'(r_free_cnt) == W - popcount(POPCNT_MAX_W'(r_occ)));

endmodule

// File: tb/tb_circ_slot_alloc.sv
// Scoreboard bench for circ_slot_alloc over three configurations (W=8 RR, W=6 RR, W=8 lowest-first).
module tb_circ_slot_alloc;

    typedef struct {
        logic [7:0] occ;
        int         cnt;
        bit         err;
        bit         rdy;
    } st_t;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_cfg
        localparam int W  = (g == 1) ? 6 : 8;
        localparam bit RR = (g == 2) ? 1'b0 : 1'b1;
        localparam int IW = $clog2(W);

        logic          arst;
        logic          flush;
        logic          avld;
        logic          ardy;
        logic [IW-1:0] aid;
        logic [W-1:0]  aoh;
        logic          fvld;
        logic [IW-1:0] fid;
        logic [IW:0]   fcnt;
        logic [W-1:0]  occ;
        logic          err;

        bit  m_occ[W];
        int  m_ptr;
        bit  m_err;
        st_t q_st[$];
        int  q_id[$];
        st_t e_st;
        int  e_id;
        bit  done = 1'b0;

        circ_slot_alloc #(
            .W           (W),
            .ROUND_ROBIN (RR)
        ) u_dut (
            .clk         (clk),
            .arst        (arst),
            .flush_i     (flush),
            .alloc_vld_i (avld),
            .alloc_rdy_o (ardy),
            .alloc_id_o  (aid),
            .alloc_oh_o  (aoh),
            .free_vld_i  (fvld),
            .free_id_i   (fid),
            .free_cnt_o  (fcnt),
            .occ_o       (occ),
            .err_o       (err)
        );

        // Reference model: occupancy as a bit array, circular scan with modulo arithmetic.
        task automatic step(input bit v, input bit fv, input int fi, input bit fl);
            st_t s;
            int  start;
            int  gid;
            int  nfree;
            @(negedge clk);
            nfree = 0;
            s.occ = '0;
            for (int i = 0; i < W; i++) begin
                s.occ[i] = m_occ[i];
                if (!m_occ[i]) nfree++;
            end
            s.cnt = nfree;
            s.err = m_err;
            s.rdy = (nfree > 0);
            q_st.push_back(s);
            if (fl) v = 1'b0;
            gid = -1;
            if (v) begin
                start = RR ? m_ptr : 0;
                for (int k = 0; k < W; k++) begin
                    if (gid < 0 && !m_occ[(start + k) % W]) gid = (start + k) % W;
                end
                if (gid >= 0) q_id.push_back(gid);
            end
            if (fl) begin
                for (int i = 0; i < W; i++) m_occ[i] = 1'b0;
                m_ptr = 0;
            end else begin
                if (fv) begin
                    if (fi >= W || !m_occ[fi]) m_err = 1'b1;
                    else m_occ[fi] = 1'b0;
                end
                if (gid >= 0) begin
                    m_occ[gid] = 1'b1;
                    if (RR) m_ptr = (gid + 1) % W;
                end
            end
            avld  = v;
            fvld  = fv;
            fid   = IW'(fi);
            flush = fl;
        endtask

        task automatic do_reset();
            @(negedge clk);
            #3;
            avld  = 1'b0;
            fvld  = 1'b0;
            fid   = '0;
            flush = 1'b0;
            arst  = 1'b1;
            for (int i = 0; i < W; i++) m_occ[i] = 1'b0;
            m_ptr = 0;
            m_err = 1'b0;
            #1;
            chk($sformatf("c%0d reset occ", g), 64'(occ), 64'd0);
            chk($sformatf("c%0d reset free_cnt", g), 64'(fcnt), 64'(W));
            chk($sformatf("c%0d reset err", g), 64'(err), 64'd0);
            chk($sformatf("c%0d reset rdy", g), 64'(ardy), 64'd1);
            chk($sformatf("c%0d reset id", g), 64'(aid), 64'd0);
            chk($sformatf("c%0d reset oh", g), 64'(aoh), 64'd1);
            @(negedge clk);
            #3;
            arst = 1'b0;
        endtask

        always @(negedge clk) begin
            #2;
            if (q_st.size() > 0) begin
                e_st = q_st.pop_front();
                chk($sformatf("c%0d occ", g), 64'(occ), 64'(e_st.occ));
                chk($sformatf("c%0d free_cnt", g), 64'(fcnt), 64'(e_st.cnt));
                chk($sformatf("c%0d err", g), 64'(err), 64'(e_st.err));
                chk($sformatf("c%0d rdy", g), 64'(ardy), 64'(e_st.rdy));
                if (avld && ardy) begin
                    if (q_id.size() == 0) begin
                        chk($sformatf("c%0d unexpected grant id", g), 64'(aid), 64'hFFFF);
                    end else begin
                        e_id = q_id.pop_front();
                        chk($sformatf("c%0d grant id", g), 64'(aid), 64'(e_id));
                        chk($sformatf("c%0d grant oh", g), 64'(aoh), 64'd1 << e_id);
                    end
                end
            end
        end

        initial begin
            arst  = 1'b1;
            avld  = 1'b0;
            fvld  = 1'b0;
            fid   = '0;
            flush = 1'b0;
            do_reset();
            // Fill past capacity, then free two and reallocate them.
            for (int i = 0; i <= W; i++) step(1, 0, 0, 0);
            step(0, 1, 3, 0);
            step(0, 1, W - 2, 0);
            step(1, 0, 0, 0);
            step(1, 0, 0, 0);
            // Full plus same-cycle free: no grant until the next cycle.
            step(1, 1, 2, 0);
            step(1, 0, 0, 0);
            step(0, 0, 0, 1);
            for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
            step(0, 1, 1, 0);
            step(1, 0, 0, 0);
            step(1, 0, 0, 0);
            step(0, 0, 0, 1);
            for (int i = 0; i < W; i++) step(1, 0, 0, 0);
            step(0, 1, 0, 0);
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
            // Illegal free is sticky through flush.
            step(0, 0, 0, 1);
            step(0, 1, 5, 0);
            step(0, 0, 0, 0);
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
            do_reset();
            step(0, 0, 0, 1);
            step(1, 1, 0, 0);
            step(0, 0, 0, 0);
            do_reset();
            for (int i = 0; i < 400; i++) begin
                if (i == 200) do_reset();
                step($urandom % 10 < 7, $urandom % 10 < 4,
                     int'($urandom_range(0, (1 << IW) - 1)), $urandom % 50 == 0);
            end
            step(0, 0, 0, 0);
            do_reset();
            chk($sformatf("c%0d leftover grants", g), 64'(q_id.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 30000; c++) begin
            if (gen_cfg[0].done && gen_cfg[1].done && gen_cfg[2].done) break;
            @(posedge clk);
        end
        if (!(gen_cfg[0].done && gen_cfg[1].done && gen_cfg[2].done)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: stimulus not complete, got 0 expected 1");
        end
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
